fu_pipe: RTL and testbench

Pipelined, handshaked 16-bit function unit that executes one `fs_t` operation per accepted request and returns the result with N/Z/C/V flags. Sits between the datapath operand bus and the register-file writeback stage. It replaces the combinational function unit wherever the issue stage must tolerate writeback backpressure. Two register stages give one-per-cycle throughput with a fixed two-cycle latency.

---
 rtl/mycpu_pkg.sv | 35 +++
 rtl/fu_alu_comb.sv | 63 ++++++
 rtl/fu_pipe.sv | 89 ++++++++
 tb/tb_fu_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared function-select codes and flag types for the function units
package mycpu_pkg;

  typedef enum logic [3:0] {
    FS_A     = 4'h0,
    FS_INC   = 4'h1,
    FS_ADD   = 4'h2,
    FS_ADDC  = 4'h3,
    FS_ADDNB = 4'h4,
    FS_SUB   = 4'h5,
    FS_DEC   = 4'h6,
    FS_A2    = 4'h7,
    FS_AND   = 4'h8,
    FS_OR    = 4'h9,
    FS_XOR   = 4'hA,
    FS_NOTA  = 4'hB,
    FS_B     = 4'hC,
    FS_SHR   = 4'hD,
    FS_SHL   = 4'hE,
    FS_ZERO  = 4'hF
  } fs_t;

  localparam int NZ_N = 0;
  localparam int NZ_Z = 1;
  localparam int CV_C = 0;
  localparam int CV_V = 1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } fu_flags_t;

endpackage

// File: rtl/fu_alu_comb.sv
// rtl/fu_alu_comb.sv - combinational function unit: a, b, fs -> f and N/Z/C/V
module fu_alu_comb
  import mycpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  fs_t           fs,
  output logic [DW-1:0] f,
  output fu_flags_t     flags
);

  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          cin;
  logic          arith;
  logic [DW:0]   sum;

  // Codes 1-6 all reduce to one adder with a selected second operand and carry-in
  always_comb begin
    x     = a;
    y     = '0;
    cin   = 1'b0;
    arith = 1'b1;
    case (fs)
      FS_INC:   cin = 1'b1;
      FS_ADD:   y = b;
      FS_ADDC:  begin y = b; cin = 1'b1; end
      FS_ADDNB: y = ~b;
      FS_SUB:   begin y = ~b; cin = 1'b1; end
      FS_DEC:   y = '1;
      default:  arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, cin};

  always_comb begin
    f     = '0;
    flags = '0;
    if (arith) begin
      f       = sum[DW-1:0];
      flags.c = sum[DW];
      flags.v = (x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1]);
    end else begin
      case (fs)
        FS_A, FS_A2: f = a;
        FS_AND:      f = a & b;
        FS_OR:       f = a | b;
        FS_XOR:      f = a ^ b;
        FS_NOTA:     f = ~a;
        FS_B:        f = b;
        FS_SHR:      begin f = {1'b0, b[DW-1:1]}; flags.c = b[0]; end
        FS_SHL:      begin f = {b[DW-2:0], 1'b0}; flags.c = b[DW-1]; end
        default:     f = '0;
      endcase
    end
    flags.n = f[DW-1];
    flags.z = (f == '0);
  end

endmodule

// File: rtl/fu_pipe.sv
// rtl/fu_pipe.sv - two-stage valid/ready pipeline around fu_alu_comb
module fu_pipe
  import mycpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  fs_t           fs_in,
  input  logic [TW-1:0] tag_in,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] f_out,
  output logic [1:0]    nz_out,
  output logic [1:0]    cv_out,
  output logic [TW-1:0] tag_out
);

  logic          s1_valid;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  fs_t           s1_fs;
  logic [TW-1:0] s1_tag;
  logic          s2_valid;
  logic          s2_free;
  logic          s1_move;
  logic          accept;
  logic [DW-1:0] alu_f;
  fu_flags_t     alu_flags;

  assign s2_free   = !s2_valid || rsp_ready;
  assign s1_move   = s1_valid && s2_free;
  assign req_ready = !s1_valid || s2_free;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_fs    <= FS_A;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_free);
      if (accept) begin
        s1_a   <= a_in;
        s1_b   <= b_in;
        s1_fs  <= fs_in;
        s1_tag <= tag_in;
      end
    end
  end

  fu_alu_comb #(.DW(DW)) u_alu (
    .a     (s1_a),
    .b     (s1_b),
    .fs    (s1_fs),
    .f     (alu_f),
    .flags (alu_flags)
  );

  // Reset value of nz_out describes the all-zero result held in f_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      f_out    <= '0;
      nz_out   <= 2'b10;
      cv_out   <= 2'b00;
      tag_out  <= '0;
    end else begin
      s2_valid <= s1_move || (s2_valid && !rsp_ready);
      if (s1_move) begin
        f_out        <= alu_f;
        nz_out[NZ_N] <= alu_flags.n;
        nz_out[NZ_Z] <= alu_flags.z;
        cv_out[CV_C] <= alu_flags.c;
        cv_out[CV_V] <= alu_flags.v;
        tag_out      <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fu_pipe.sv
// tb/tb_fu_pipe.sv - scoreboard bench for fu_pipe with random stimulus and a reference model
module tb_fu_pipe;
  import mycpu_pkg::*;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] f;
    logic [1:0]  nz;
    logic [1:0]  cv;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  fs_t         fs_in;
  logic [3:0]  tag_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] f_out;
  logic [1:0]  nz_out;
  logic [1:0]  cv_out;
  logic [3:0]  tag_out;

  int   checks = 0;
  int   passes = 0;
  int   rsp_count = 0;
  int   run_len = 0;
  int   max_run = 0;
  bit   prev_hs = 0;
  exp_t sb[$];

  fu_pipe #(.DW(16), .TW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .fs_in     (fs_in),
    .tag_in    (tag_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .f_out     (f_out),
    .nz_out    (nz_out),
    .cv_out    (cv_out),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] tag);
    exp_t        e;
    logic [15:0] y;
    int          cin, us, ss;
    bit          ar;
    e   = '0;
    y   = '0;
    cin = 0;
    ar  = 1;
    case (fs)
      4'h1: cin = 1;
      4'h2: y = b;
      4'h3: begin y = b; cin = 1; end
      4'h4: y = ~b;
      4'h5: begin y = ~b; cin = 1; end
      4'h6: y = 16'hFFFF;
      default: ar = 0;
    endcase
    if (ar) begin
      us       = int'(a) + int'(y) + cin;
      ss       = int'($signed(a)) + int'($signed(y)) + cin;
      e.f      = us[15:0];
      e.cv[0]  = (us > 65535);
      e.cv[1]  = (ss > 32767) || (ss < -32768);
    end else begin
      case (fs)
        4'h0, 4'h7: e.f = a;
        4'h8: e.f = a & b;
        4'h9: e.f = a | b;
        4'hA: e.f = a ^ b;
        4'hB: e.f = ~a;
        4'hC: e.f = b;
        4'hD: begin e.f = b >> 1; e.cv[0] = b[0]; end
        4'hE: begin e.f = b << 1; e.cv[0] = b[15]; end
        default: e.f = 16'h0000;
      endcase
    end
    e.nz  = {(e.f == 16'h0000), e.f[15]};
    e.tag = tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    #1;
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      run_len = prev_hs ? run_len + 1 : 1;
      prev_hs = 1;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected tag=%h f=%h", tag_out, f_out);
      end else begin
        chk("rsp_tag_f_nz_cv", {8'h0, tag_out, f_out, nz_out, cv_out}, {8'h0, sb.pop_front()});
      end
    end else begin
      prev_hs = 0;
    end
  end

  task automatic send(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic rr);
    int n;
    n = 0;
    @(negedge clk);
    fs_in = fs_t'(fs); a_in = a; b_in = b; tag_in = tag;
    req_valid = 1'b1; rsp_ready = rr;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready) sb.push_back(model(fs, a, b, tag));
    else begin
      checks++;
      $display("FAIL send_timeout actual=req_ready_low required=accept_within_50");
    end
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = rr;
    end
  endtask

  task automatic directed(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, input logic [15:0] ef, input logic [1:0] enz,
                          input logic [1:0] ecv);
    send(fs, a, b, tag, 1'b1);
    idle(1, 1'b1);
    #2 chk("lat_not_early", rsp_valid, 1'b0);
    idle(1, 1'b1);
    #2 chk("lat_valid", rsp_valid, 1'b1);
    chk("dir_result", {tag_out, f_out, nz_out, cv_out}, {tag, ef, enz, ecv});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t        e0;
    logic [15:0] ra, rb;
    int          cnt0;
    bit          acc;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    a_in = '0; b_in = '0; fs_in = FS_A; tag_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outputs", {tag_out, f_out, nz_out, cv_out}, {4'h0, 16'h0000, 2'b10, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_req_ready", req_ready, 1'b1);

    // Directed corner cases: N=bit0/Z=bit1, C=bit0/V=bit1
    directed(4'h2, 16'h7FFF, 16'h0001, 4'h5, 16'h8000, 2'b01, 2'b10);
    directed(4'h5, 16'h1234, 16'h1234, 4'h6, 16'h0000, 2'b10, 2'b01);
    directed(4'hD, 16'h5555, 16'h0003, 4'h7, 16'h0001, 2'b00, 2'b01);
    directed(4'hE, 16'h1111, 16'h8000, 4'h8, 16'h0000, 2'b10, 2'b01);
    directed(4'hF, 16'hFFFF, 16'hFFFF, 4'h9, 16'h0000, 2'b10, 2'b00);

    // Back-to-back: every code once, tags in order
    idle(2, 1'b1);
    max_run = 0;
    cnt0 = rsp_count;
    for (int i = 0; i < 16; i++)
      send(4'(i), 16'($urandom), 16'($urandom), 4'(i), 1'b1);
    #1 chk("b2b_inflight", rsp_count - cnt0, 14);
    idle(2, 1'b1);
    #2 chk("b2b_count", rsp_count - cnt0, 16);
    chk("b2b_consecutive", max_run, 16);

    // Backpressure: fill, hold, then drain and accept in one cycle
    idle(2, 1'b1);
    ra = 16'($urandom); rb = 16'($urandom);
    e0 = model(4'h2, ra, rb, 4'hA);
    send(4'h2, ra, rb, 4'hA, 1'b0);
    send(4'h9, 16'($urandom), 16'($urandom), 4'hB, 1'b0);
    ra = 16'($urandom); rb = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fs_in = FS_SUB; a_in = ra; b_in = rb; tag_in = 4'hC;
      req_valid = 1'b1; rsp_ready = 1'b0;
      #1;
      chk("full_req_ready", req_ready, 1'b0);
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_hold", {tag_out, f_out, nz_out, cv_out}, e0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("drain_accept_ready", req_ready, 1'b1);
    sb.push_back(model(4'h5, ra, rb, 4'hC));
    idle(4, 1'b1);
    #2 chk("drain_empty", sb.size(), 0);

    // Reset with both stages occupied
    send(4'h3, 16'($urandom), 16'($urandom), 4'h1, 1'b0);
    send(4'h8, 16'($urandom), 16'($urandom), 4'h2, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_nz", nz_out, 2'b10);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle(1, 1'b1);
      #2 chk("no_stale_rsp", rsp_valid, 1'b0);
    end

    // Randomized handshakes on both sides
    acc = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (acc) req_valid = 1'b0;
      if (!req_valid && $urandom_range(0, 2) != 0) begin
        fs_in = fs_t'($urandom_range(0, 15));
        a_in = 16'($urandom); b_in = 16'($urandom); tag_in = 4'($urandom);
        req_valid = 1'b1;
      end
      #1;
      acc = req_valid && req_ready;
      if (acc) sb.push_back(model(fs_in, a_in, b_in, tag_in));
    end
    idle(10, 1'b1);
    #2 chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
